matriz_leds_param: RTL
======================

MATRIZ_LEDS_PARAM -- requirements
Module: matriz_leds_param

Interface
REQ-001 Parameter ROWS, default 8: matrix rows, 2..16.
REQ-002 Parameter COLS, default 8: matrix columns, 2..16.
REQ-003 Parameter NBTN, default 8: button count, 1..16.
REQ-004 Parameter SCAN_DIV, default 1000: clocks per scanned row, >=1.
REQ-005 Port clk  input  1  single clock; all state on rising edge.
REQ-006 Port rst  input  1  asynchronous, active-low reset.
REQ-007 Port botoes  input  NBTN  button levels, 1 = pressed, already synchronised.
REQ-008 Port nivel  input  3  current player level.
REQ-009 Port limpar  input  1  synchronous board clear.
REQ-010 Port mask_we  input  1  toggle-mask write strobe.
REQ-011 Port mask_sel  input  4  button index of the mask being written.
REQ-012 Port mask_data  input  ROWS*COLS  mask; bit r*COLS+c = cell (r,c).
REQ-013 Port colunas  output  COLS  column drive for the active row, 1 = LED on.
REQ-014 Port linhas  output  ROWS  row select, one-hot active-low.
REQ-015 Port nivel_concluido  output  1  level-complete flag, registered.
REQ-016 Port vitoria_pulso  output  1  one-cycle pulse on completion.
REQ-017 Port jogadas  output  16  move counter.

Function
REQ-018 Per-button toggle masks SHALL be held in NBTN registers of ROWS*COLS bits each.
REQ-019 mask_we=1 with mask_sel<NBTN SHALL write mask_data to that mask on the same edge; mask_sel>=NBTN SHALL be ignored.
REQ-020 Press event = botoes & ~botoes_q, with botoes_q being botoes registered one cycle; holding a button SHALL produce exactly one event.
REQ-021 On an edge where any event is present and limpar=0, the board SHALL be updated to board XOR (XOR of masks of all pressed-event buttons); overlapping cells toggled an even number of times stay unchanged.
REQ-022 A press on the same edge as a mask write SHALL use the old mask value.
REQ-023 limpar=1 SHALL clear the board and jogadas to 0 and discard same-cycle press events; masks are kept.
REQ-024 jogadas SHALL increment by 1 per cycle containing >=1 press event, and saturate at 16'hFFFF.
REQ-025 Required rows N = min(2*nivel+1, ROWS); nivel_concluido SHALL be 1 exactly when rows 0..N-1 of the board are all ones, registered one cycle after the board state.
REQ-026 vitoria_pulso SHALL be high for one cycle on the edge where nivel_concluido goes 0->1, and SHALL NOT re-fire while it stays 1.
REQ-027 Scan: the prescaler SHALL count 0..SCAN_DIV-1; at terminal count linha_atual advances by 1, wrapping from ROWS-1 to 0.
REQ-028 linhas SHALL equal ~(1<<linha_atual); colunas SHALL equal board row linha_atual, both registered and updated on the same edge.
REQ-029 The scan SHALL run independently of limpar, presses, and mask writes.

Reset
REQ-030 rst=0 SHALL asynchronously set the board, masks, jogadas, prescaler, linha_atual, nivel_concluido, and vitoria_pulso to 0, and botoes_q to all ones.
REQ-031 During reset, colunas=0 and linhas=~1 (row 0 selected).
REQ-032 A button held across reset release SHALL NOT generate an event until it has been released and pressed again.
REQ-033 Reset asserted mid-scan or mid-press SHALL take effect immediately, without waiting for a clock edge.

Verification
REQ-034 Write mask 0 = row 0 all ones, nivel=0, pulse botoes[0] for one cycle -> board row0 = all ones, jogadas=1, nivel_concluido=1 one cycle later, vitoria_pulso one cycle.
REQ-035 Hold botoes[0] for 20 cycles -> exactly one toggle, jogadas=1.
REQ-036 Masks 0 and 1 overlap at cell (0,0); press both in the same cycle -> cell (0,0) unchanged, other cells toggled, jogadas=1.
REQ-037 SCAN_DIV=3, ROWS=8 -> linhas walks ~1, ~2, ... ~128, ~1 with 3 clocks per row; colunas matches the board row.
REQ-038 Force jogadas to 16'hFFFF, then press -> stays 16'hFFFF; then limpar=1 together with a press -> board=0, jogadas=0, no toggle.
REQ-039 Assert rst mid-operation with botoes[2] held -> all outputs reset asynchronously; after release, no event until botoes[2] is released and pressed again.

Source files
------------

// File: rtl/matriz_leds_param_if.sv
// matriz_leds_param_if -- control/status bundle for the LED-matrix game core. Rev 1.0
`default_nettype none

interface matriz_leds_param_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int NBTN = 8
);
  logic [NBTN-1:0]      botoes;
  logic [2:0]           nivel;
  logic                 limpar;
  logic                 mask_we;
  logic [3:0]           mask_sel;
  logic [ROWS*COLS-1:0] mask_data;
  logic [COLS-1:0]      colunas;
  logic [ROWS-1:0]      linhas;
  logic                 nivel_concluido;
  logic                 vitoria_pulso;
  logic [15:0]          jogadas;

  modport master (
    output botoes, nivel, limpar, mask_we, mask_sel, mask_data,
    input  colunas, linhas, nivel_concluido, vitoria_pulso, jogadas
  );

  modport slave (
    input  botoes, nivel, limpar, mask_we, mask_sel, mask_data,
    output colunas, linhas, nivel_concluido, vitoria_pulso, jogadas
  );
endinterface

`default_nettype wire

// File: rtl/matriz_leds_param.sv
// matriz_leds_param -- lights-out style LED-matrix game core with row-multiplexed scan. Rev 1.0
`default_nettype none

module matriz_leds_param #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int NBTN     = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  matriz_leds_param_if.slave bus
);

  localparam int CELLS = ROWS * COLS;
  localparam int LW    = $clog2(ROWS);
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CELLS-1:0] masks_q [NBTN];
  logic [CELLS-1:0] masks_d [NBTN];
  logic [CELLS-1:0] board_q, board_d;
  logic [CELLS-1:0] toggle_w, req_w;
  logic [NBTN-1:0]  botoes_q, ev_w;
  logic [15:0]      jogadas_q, jogadas_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [LW-1:0]    linha_q, linha_d;
  logic [ROWS-1:0]  linhas_q, linhas_d;
  logic [COLS-1:0]  colunas_q, colunas_d;
  logic             conc_q, conc_d;
  logic             vit_q, vit_d;

  always_comb begin
    ev_w      = bus.botoes & ~botoes_q;
    toggle_w  = '0;
    board_d   = board_q;
    jogadas_d = jogadas_q;
    req_w     = '0;
    presc_d   = presc_q;
    linha_d   = linha_q;
    colunas_d = '0;

    // Overlapping masks cancel naturally through the XOR reduction.
    for (int b = 0; b < NBTN; b++) begin
      if (ev_w[b]) toggle_w = toggle_w ^ masks_q[b];
    end

    if (bus.limpar) begin
      board_d   = '0;
      jogadas_d = '0;
    end else if (|ev_w) begin
      board_d = board_q ^ toggle_w;
      if (jogadas_q != 16'hFFFF) jogadas_d = jogadas_q + 16'd1;
    end

    // Writes land after the toggle, so a same-edge press sees the old mask.
    for (int b = 0; b < NBTN; b++) begin
      masks_d[b] = masks_q[b];
      if (bus.mask_we && (bus.mask_sel == 4'(b))) masks_d[b] = bus.mask_data;
    end

    for (int r = 0; r < ROWS; r++) begin
      if (r < 2 * int'(bus.nivel) + 1) req_w[r*COLS +: COLS] = '1;
    end
    conc_d = ((board_q & req_w) == req_w);
    vit_d  = conc_d & ~conc_q;

    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      linha_d = (linha_q == LW'(ROWS - 1)) ? '0 : linha_q + LW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Outputs follow the next row and next board so they always agree.
    linhas_d = ~(ROWS'(1) << linha_d);
    for (int r = 0; r < ROWS; r++) begin
      if (linha_d == LW'(r)) colunas_d = board_d[r*COLS +: COLS];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NBTN; b++) masks_q[b] <= '0;
      board_q   <= '0;
      botoes_q  <= '1;
      jogadas_q <= '0;
      presc_q   <= '0;
      linha_q   <= '0;
      linhas_q  <= ~ROWS'(1);
      colunas_q <= '0;
      conc_q    <= 1'b0;
      vit_q     <= 1'b0;
    end else begin
      for (int b = 0; b < NBTN; b++) masks_q[b] <= masks_d[b];
      board_q   <= board_d;
      botoes_q  <= bus.botoes;
      jogadas_q <= jogadas_d;
      presc_q   <= presc_d;
      linha_q   <= linha_d;
      linhas_q  <= linhas_d;
      colunas_q <= colunas_d;
      conc_q    <= conc_d;
      vit_q     <= vit_d;
    end
  end

  assign bus.colunas         = colunas_q;
  assign bus.linhas          = linhas_q;
  assign bus.nivel_concluido = conc_q;
  assign bus.vitoria_pulso   = vit_q;
  assign bus.jogadas         = jogadas_q;

endmodule

`default_nettype wire
